// File: rtl/iter_muldiv.sv
// Iterative 16-bit unsigned multiply/divide unit: one shift-add or restoring-division step per cycle.
// Define MULDIV_DIV_EN to build the divider (DIV/REM); without it op=1x completes at once with err=1.
module iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       dst_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       dst_out,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q;      // multiplicand or divisor
  logic [WIDTH-1:0] hi_q;     // product high half or partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier / product low half, or dividend / quotient
  logic             res_hi_q; // op[0]: select the high register as the result
  logic [2:0]       dst_q;
  logic [4:0]       cnt_q;
`ifdef MULDIV_DIV_EN
  logic             is_div_q;
`endif

  logic             accept;
  logic             last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic             err_sel;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt_q == 5'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef MULDIV_DIV_EN
          state_nxt = RUN;
`else
          state_nxt = op[1] ? DONE : RUN;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply step: add the multiplicand if the multiplier LSB is set, then shift right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);

`ifdef MULDIV_DIV_EN
  // Restoring division step: shift the next dividend bit in, subtract if it fits.
  logic [WIDTH:0] div_part, div_diff;
  logic           div_ge;
  assign div_part = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_part - {1'b0, a_q};
  assign div_ge   = (div_part >= {1'b0, a_q});

  always_comb begin
    iter_hi = mul_sum[WIDTH:1];
    iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  assign err_sel = is_div_q && (a_q == '0);
`else
  assign iter_hi = mul_sum[WIDTH:1];
  assign iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign err_sel = 1'b0;
`endif

  // NOTE: every datapath register, not only the FSM, is cleared by the async reset so an
  // aborted operation leaves no residue in the accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= 1'b0;
      dst_q    <= '0;
      cnt_q    <= '0;
      result   <= '0;
      dst_out  <= '0;
      err      <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_hi_q <= op[0];
        dst_q    <= dst_in;
        cnt_q    <= '0;
        hi_q     <= '0;
`ifdef MULDIV_DIV_EN
        is_div_q <= op[1];
        a_q      <= op[1] ? opB : opA;
        lo_q     <= op[1] ? opA : opB;
`else
        a_q      <= opA;
        lo_q     <= opB;
        if (op[1]) begin
          result  <= '0;
          err     <= 1'b1;
          dst_out <= dst_in;
        end
`endif
      end else if (state == RUN) begin
        hi_q  <= iter_hi;
        lo_q  <= iter_lo;
        cnt_q <= cnt_q + 5'd1;
        if (last) begin
          result  <= res_hi_q ? iter_hi : iter_lo;
          err     <= err_sel;
          dst_out <= dst_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed self-checking bench for iter_muldiv; expectations follow MULDIV_DIV_EN when defined.
module tb_iter_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opA, opB;
  logic [2:0]  dst_in;
  logic        busy, done, err;
  logic [15:0] result;
  logic [2:0]  dst_out;

  int checks = 0;
  int errors = 0;

  iter_muldiv #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .opA     (opA),
    .opB     (opB),
    .dst_in  (dst_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .dst_out (dst_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the operation is accepted on the following posedge.
  task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d);
    op     = o;
    opA    = a;
    opB    = b;
    dst_in = d;
    start  = 1'b1;
    @(posedge clk);
  endtask

  // Waits for done (bounded), scrambling operands after accept and optionally
  // pulsing a stray start at cycle stray_at. Returns at the negedge inside the done cycle.
  task automatic finish_op(input string tag, input logic [15:0] exp_res, input logic exp_err,
                           input logic [2:0] exp_dst, input int exp_lat, input int stray_at);
    int          lat;
    int          bcnt;
    logic [15:0] prev;
    bit          held;
    lat  = 0;
    bcnt = 0;
    prev = result;
    held = 1'b1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start  = 1'b0;
        opA    = 16'($urandom);
        opB    = 16'($urandom);
        dst_in = 3'($urandom);
      end
      if (lat == stray_at) begin
        start = 1'b1;
        op    = 2'b01;
        opA   = 16'h5555;
        opB   = 16'h3333;
      end
      if (lat == stray_at + 1) start = 1'b0;
      if (busy) bcnt++;
      if (busy && result !== prev) held = 1'b0;
      if (done || lat >= 40) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_lat - 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_dst"}, dst_out, exp_dst);
    check({tag, "_held_in_run"}, held, 1'b1);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int          div_lat;
    logic        div_ok;
    bit          saw_done;
`ifdef MULDIV_DIV_EN
    div_lat = 17;
    div_ok  = 1'b1;
`else
    div_lat = 1;
    div_ok  = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0; dst_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_dst", dst_out, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(2'b00, 16'h0123, 16'h0045, 3'd3);
    finish_op("mul", 16'h4E6F, 1'b0, 3'd3, 17, -1);
    pulse_end("mul");

    launch(2'b01, 16'hFFFF, 16'hFFFF, 3'd5);
    finish_op("mulh_ffff", 16'hFFFE, 1'b0, 3'd5, 17, -1);
    pulse_end("mulh_ffff");

    launch(2'b00, 16'hFFFF, 16'hFFFF, 3'd6);
    finish_op("mul_ffff", 16'h0001, 1'b0, 3'd6, 17, -1);
    pulse_end("mul_ffff");

    launch(2'b10, 16'h0064, 16'h0007, 3'd1);
    finish_op("div", div_ok ? 16'h000E : 16'h0000, !div_ok, 3'd1, div_lat, -1);
    pulse_end("div");

    launch(2'b11, 16'h0064, 16'h0007, 3'd2);
    finish_op("rem", div_ok ? 16'h0002 : 16'h0000, !div_ok, 3'd2, div_lat, -1);
    pulse_end("rem");

    launch(2'b10, 16'h1234, 16'h0000, 3'd4);
    finish_op("div0", div_ok ? 16'hFFFF : 16'h0000, 1'b1, 3'd4, div_lat, -1);
    pulse_end("div0");

    launch(2'b11, 16'h1234, 16'h0000, 3'd7);
    finish_op("rem0", div_ok ? 16'h1234 : 16'h0000, 1'b1, 3'd7, div_lat, -1);
    pulse_end("rem0");

    // Stray start in the middle of RUN must not disturb the operation.
    launch(2'b00, 16'h0003, 16'h0005, 3'd2);
    finish_op("stray", 16'h000F, 1'b0, 3'd2, 17, 5);
    pulse_end("stray");

    // Reset in the middle of RUN aborts with no done pulse.
    launch(2'b00, 16'h0101, 16'h0101, 3'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_dst", dst_out, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);
    launch(2'b00, 16'h00FF, 16'h0002, 3'd1);
    finish_op("after_rst", 16'h01FE, 1'b0, 3'd1, 17, -1);
    pulse_end("after_rst");

    // Back-to-back: second start accepted during the done cycle.
    launch(2'b00, 16'h0010, 16'h0010, 3'd4);
    finish_op("b2b_first", 16'h0100, 1'b0, 3'd4, 17, -1);
    launch(2'b01, 16'h8000, 16'h0004, 3'd5);
    finish_op("b2b_second", 16'h0002, 1'b0, 3'd5, 17, -1);
    pulse_end("b2b_second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
